// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Drains the ps2_keyboard scan-code FIFO one byte per IDLE/ACK/DECODE pass and
// folds E0/F0 prefixes into single key events (code, ext, break, ASCII).
// Tracks the currently held key, optionally filters typematic repeats and
// counts accepted presses.
// Optional feature macro: PS2_SHIFT_CASE_EN -- tracks left/right shift and
// emits lowercase letters unless a shift key is held.
module ps2_scancode_decoder #(
  parameter int CNT_W         = 8,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  code_r;
  logic        ext_r;
  logic        brk_r;
  logic        held_ext_r;
  logic        same_s;
  logic        upper_s;
  logic [7:0]  ascii_s;
`ifdef PS2_SHIFT_CASE_EN
  logic        lshift_r;
  logic        rshift_r;
  logic        is_shift_s;
`endif

  // Set-2 scan code to ASCII; extended codes and unmapped keys give 8'h00.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       ext,
                                               input logic       upper);
    logic [7:0] a;
    case (code)
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
      8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
      8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
      8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
      8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
      default: a = 8'h00;
    endcase
    if (ext) begin
      a = 8'h00;
    end else if (!upper && (a >= 8'h41) && (a <= 8'h5A)) begin
      a = a + 8'h20;
    end else begin
      a = a;
    end
    return a;
  endfunction

  // Decode helpers for the byte waiting in code_r.
  always_comb begin
    same_s = key_held && (held_code == code_r) && (held_ext_r == ext_r);
`ifdef PS2_SHIFT_CASE_EN
    upper_s    = lshift_r | rshift_r;
    is_shift_s = !ext_r && ((code_r == 8'h12) || (code_r == 8'h59));
`else
    upper_s    = 1'b1;
`endif
    ascii_s = scan_to_ascii(code_r, ext_r, upper_s);
  end

  // Handshake FSM, prefix folding, held-key tracking and press counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r    <= S_IDLE;
      code_r     <= 8'h00;
      ext_r      <= 1'b0;
      brk_r      <= 1'b0;
      held_ext_r <= 1'b0;
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_ascii  <= 8'h00;
      key_held   <= 1'b0;
      held_code  <= 8'h00;
      press_cnt  <= '0;
`ifdef PS2_SHIFT_CASE_EN
      lshift_r   <= 1'b0;
      rshift_r   <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (kb_ready) begin
            code_r     <= kb_data;
            nextdata_n <= 1'b0;
            state_r    <= S_ACK;
          end else begin
            nextdata_n <= 1'b1;
            state_r    <= S_IDLE;
          end
        end
        S_ACK: begin
          // The producer advances its read pointer on this edge.
          nextdata_n <= 1'b1;
          state_r    <= S_DECODE;
        end
        S_DECODE: begin
          nextdata_n <= 1'b1;
          state_r    <= S_IDLE;
          if (code_r == 8'hE0) begin
            ext_r <= 1'b1;
          end else if (code_r == 8'hF0) begin
            brk_r <= 1'b1;
          end else begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
`ifdef PS2_SHIFT_CASE_EN
            if (is_shift_s) begin
              // Shift keys report an event but never become the held key.
              key_valid <= 1'b1;
              key_code  <= code_r;
              key_ext   <= ext_r;
              key_break <= brk_r;
              key_ascii <= ascii_s;
              if (code_r == 8'h12) begin
                lshift_r <= ~brk_r;
              end else begin
                rshift_r <= ~brk_r;
              end
            end else
`endif
            if (brk_r) begin
              key_valid <= 1'b1;
              key_code  <= code_r;
              key_ext   <= ext_r;
              key_break <= 1'b1;
              key_ascii <= ascii_s;
              if (same_s) begin
                key_held <= 1'b0;
              end else begin
                key_held <= key_held;
              end
            end else if (same_s && (REPEAT_FILTER == 1'b1)) begin
              // Typematic repeat of the held key: swallowed silently.
              key_valid <= 1'b0;
            end else begin
              key_valid  <= 1'b1;
              key_code   <= code_r;
              key_ext    <= ext_r;
              key_break  <= 1'b0;
              key_ascii  <= ascii_s;
              held_code  <= code_r;
              held_ext_r <= ext_r;
              key_held   <= 1'b1;
              press_cnt  <= press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          nextdata_n <= 1'b1;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a queue models the ps2_keyboard FIFO, a
// byte-level behavioural model predicts the event stream for two instances
// (repeat filter on / 8-bit counter, repeat filter off / 4-bit counter).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;

  logic       nd [2];
  logic       kv [2];
  logic       ke [2];
  logic       kbk[2];
  logic       kh [2];
  logic [7:0] kc [2];
  logic [7:0] ka [2];
  logic [7:0] hc [2];
  logic [7:0] pc0;
  logic [3:0] pc1;

  ps2_scancode_decoder #(.CNT_W(8), .REPEAT_FILTER(1'b1)) dut0 (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .nextdata_n(nd[0]), .key_valid(kv[0]), .key_code(kc[0]), .key_ext(ke[0]),
    .key_break(kbk[0]), .key_ascii(ka[0]), .key_held(kh[0]), .held_code(hc[0]),
    .press_cnt(pc0));

  ps2_scancode_decoder #(.CNT_W(4), .REPEAT_FILTER(1'b0)) dut1 (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .nextdata_n(nd[1]), .key_valid(kv[1]), .key_code(kc[1]), .key_ext(ke[1]),
    .key_break(kbk[1]), .key_ascii(ka[1]), .key_held(kh[1]), .held_code(hc[1]),
    .press_cnt(pc1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic [7:0] hcode;
    logic       ext;
    logic       brk;
    logic       held;
    int         cnt;
  } evt_t;

  typedef struct {
    logic       ext;
    logic       brk;
    logic       held;
    logic       hext;
    logic       lsh;
    logic       rsh;
    logic [7:0] hcode;
    int         cnt;
  } mst_t;

  mst_t       ms[2];
  evt_t       q0[$];
  evt_t       q1[$];
  logic [7:0] fifo[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         nd_cnt = 0;
  int         evt_cnt[2];
  logic       nd_prev = 1'b0;

  logic [7:0] letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                               8'h3D, 8'h3E, 8'h46};
  logic [7:0] wrap_sc[16]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                               8'h43, 8'h44, 8'h4D, 8'h45, 8'h16, 8'h1E, 8'h26,
                               8'h25, 8'h2E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic ext,
                                             input logic upper);
    if (ext) return 8'h00;
    for (int i = 0; i < 10; i++) if (digit_sc[i] == c) return 8'h30 + 8'(i);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) return (upper ? 8'h41 : 8'h61) + 8'(i);
    return 8'h00;
  endfunction

  // Byte-level model of one decoder instance; k=0 filters repeats and counts
  // modulo 256, k=1 passes repeats and counts modulo 16.
  task automatic model_byte(input int k, input logic [7:0] b);
    evt_t e;
    logic upper;
    logic emit;
    logic shiftkey;
    logic same;
    if (b == 8'hE0) begin
      ms[k].ext = 1'b1;
    end else if (b == 8'hF0) begin
      ms[k].brk = 1'b1;
    end else begin
      upper = 1'b1;
      shiftkey = 1'b0;
`ifdef PS2_SHIFT_CASE_EN
      upper = ms[k].lsh || ms[k].rsh;
      shiftkey = !ms[k].ext && ((b == 8'h12) || (b == 8'h59));
`endif
      e.code = b;
      e.ext = ms[k].ext;
      e.brk = ms[k].brk;
      e.ascii = model_ascii(b, e.ext, upper);
      emit = 1'b1;
      same = ms[k].held && (ms[k].hcode == b) && (ms[k].hext == e.ext);
      if (shiftkey) begin
        if (b == 8'h12) ms[k].lsh = !e.brk;
        else ms[k].rsh = !e.brk;
      end else if (e.brk) begin
        if (same) ms[k].held = 1'b0;
      end else if (same && (k == 0)) begin
        emit = 1'b0;
      end else begin
        ms[k].held = 1'b1;
        ms[k].hcode = b;
        ms[k].hext = e.ext;
        ms[k].cnt = (ms[k].cnt + 1) % ((k == 0) ? 256 : 16);
      end
      e.held = ms[k].held;
      e.hcode = ms[k].hcode;
      e.cnt = ms[k].cnt;
      ms[k].ext = 1'b0;
      ms[k].brk = 1'b0;
      if (emit) begin
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic push1(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(0, b);
    model_byte(1, b);
  endtask

  task automatic check_evt(input int k);
    evt_t e;
    logic has;
    logic [7:0] pcv;
    pcv = (k == 0) ? pc0 : {4'h0, pc1};
    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("evt_pending%0d", k), has, 1);
    if (has) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("key_code%0d", k), kc[k], e.code);
      chk($sformatf("key_ext%0d", k), ke[k], e.ext);
      chk($sformatf("key_break%0d", k), kbk[k], e.brk);
      chk($sformatf("key_ascii%0d", k), ka[k], e.ascii);
      chk($sformatf("key_held%0d", k), kh[k], e.held);
      chk($sformatf("press_cnt%0d", k), pcv, e.cnt);
      if (e.held) chk($sformatf("held_code%0d", k), hc[k], e.hcode);
    end
  endtask

  // FIFO model: pops on the edge that sees nextdata_n low, flushes in reset.
  logic pop_now;
  initial begin
    forever begin
      @(posedge clk);
      pop_now = (nd[0] === 1'b0);
      #1;
      if (!clrn) fifo.delete();
      else if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      kb_ready = (fifo.size() > 0);
      kb_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (clrn === 1'b1) begin
        if (nd[0] === 1'b0) begin
          nd_cnt++;
          chk("nd_while_ready", kb_ready, 1);
          chk("nd_single_cycle", nd_prev, 0);
        end
        chk("nd_lockstep", nd[1], nd[0]);
        for (int k = 0; k < 2; k++) begin
          if (kv[k] === 1'b1) begin
            evt_cnt[k]++;
            check_evt(k);
          end
        end
        nd_prev = (nd[0] === 1'b0);
      end else begin
        nd_prev = 1'b0;
      end
    end
  end

  task automatic clear_counts();
    nd_cnt = 0;
    evt_cnt[0] = 0;
    evt_cnt[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_nextdata_n", nd[k], 1);
      chk("rst_key_valid", kv[k], 0);
      chk("rst_key_code", kc[k], 0);
      chk("rst_key_ext", ke[k], 0);
      chk("rst_key_break", kbk[k], 0);
      chk("rst_key_ascii", ka[k], 0);
      chk("rst_key_held", kh[k], 0);
      chk("rst_held_code", hc[k], 0);
    end
    chk("rst_press_cnt0", pc0, 0);
    chk("rst_press_cnt1", pc1, 0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) ms[k] = '{default: '0};
    q0.delete();
    q1.delete();
    clear_counts();
    #2 clrn = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fifo.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", fifo.size(), 0);
    repeat (6) @(negedge clk);
    chk("q0_all_seen", q0.size(), 0);
    chk("q1_all_seen", q1.size(), 0);
  endtask

  task automatic wait_nd_low(output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (nd[0] === 1'b0) found = 1'b1;
    end
    chk("nd_low_seen", found, 1);
  endtask

  initial begin
    logic found;
    do_reset();

    // Make/break of 'A' with latency and handshake count.
    @(negedge clk);
    #2;
    push1(8'h1C); push1(8'hF0); push1(8'h1C);
    wait_nd_low(found);
    @(negedge clk);
    chk("lat_kv_t2", kv[0], 0);
    chk("lat_nd_high_t2", nd[0], 1);
    @(negedge clk);
    chk("lat_kv_t3", kv[0], 1);
    chk("lat_code_t3", kc[0], 8'h1C);
    chk("lat_ascii_t3", ka[0], 8'h41);
    drain();
    chk("t1_nd_pulses", nd_cnt, 3);
    chk("t1_events", evt_cnt[0], 2);
    chk("t1_press_cnt", pc0, 1);
    chk("t1_held", kh[0], 0);
    chk("t1_break", kbk[0], 1);

    // Typematic repeats: filtered vs. unfiltered.
    clear_counts();
    push1(8'h1C); push1(8'h1C); push1(8'h1C); push1(8'hF0); push1(8'h1C);
    drain();
    chk("t2_events_filt", evt_cnt[0], 2);
    chk("t2_events_nofilt", evt_cnt[1], 4);
    chk("t2_cnt_filt", pc0, 2);
    chk("t2_cnt_nofilt", pc1, 4);

    // Extended keys, both prefix orders, repeated F0.
    clear_counts();
    push1(8'hE0); push1(8'h75); push1(8'hE0); push1(8'hF0); push1(8'h75);
    push1(8'hE0); push1(8'h6B); push1(8'hF0); push1(8'hE0); push1(8'h6B);
    push1(8'hF0); push1(8'hF0); push1(8'h32);
    drain();
    chk("t3_events", evt_cnt[0], 5);
    chk("t3_last_code", kc[0], 8'h32);
    chk("t3_last_ext", ke[0], 0);
    chk("t3_last_ascii", ka[0], 8'h42);
    chk("t3_held", kh[0], 0);

    // Reset during ACK after the F0 has been handed over.
    push1(8'hF0);
    wait_nd_low(found);
    #2 clrn = 1'b0;
    #1 chk("t4_nd_in_reset", nd[0], 1);
    chk("t4_kv_in_reset", kv[0], 0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) ms[k] = '{default: '0};
    q0.delete();
    q1.delete();
    clear_counts();
    #2 clrn = 1'b1;
    push1(8'h16);
    drain();
    chk("t4_code", kc[0], 8'h16);
    chk("t4_ascii", ka[0], 8'h31);
    chk("t4_break", kbk[0], 0);
    chk("t4_cnt", pc0, 1);
    chk("t4_held_code", hc[0], 8'h16);

    // Sixteen distinct presses wrap the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push1(wrap_sc[i]); push1(8'hF0); push1(wrap_sc[i]);
    end
    drain();
    chk("t5_cnt8", pc0, 16);
    chk("t5_cnt4_wrap", pc1, 0);
    chk("t5_events", evt_cnt[0], 32);

`ifdef PS2_SHIFT_CASE_EN
    // Shift held gives uppercase, released gives lowercase.
    do_reset();
    push1(8'h12); push1(8'h1C); push1(8'hF0); push1(8'h1C);
    push1(8'hF0); push1(8'h12); push1(8'h1C);
    drain();
    chk("t6_ascii_lower", ka[0], 8'h61);
    chk("t6_cnt", pc0, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
